// File: rtl/reg_file_pkg.sv
// Shared opcodes, FSM state type and sizing helper for the reg_file_bank register set.
package reg_file_pkg;

    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_WRITE     = 3'd1;
    localparam logic [2:0] OP_READ      = 3'd2;
    localparam logic [2:0] OP_MOVE      = 3'd3;
    localparam logic [2:0] OP_PAIR_ADDR = 3'd4;
    localparam logic [2:0] OP_PAIR_INC  = 3'd5;
    localparam logic [2:0] OP_PAIR_DEC  = 3'd6;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CARRY = 1'b1
    } state_t;

    // Width needed to hold a pair index; never narrower than one bit.
    function automatic int pair_idx_w(input int num_regs);
        return (num_regs > 2) ? $clog2(num_regs / 2) : 1;
    endfunction

endpackage

// File: rtl/reg_file_bank_pair_step_unit.sv
// Combinational +/-1 step with carry-out / borrow-out flag, shared between the
// low-half step and the deferred high-half step of a register pair.
module pair_step_unit
    import reg_file_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] operand,
    input  logic              dec,
    output logic [DATA_W-1:0] result,
    output logic              flag
);

    // Flag is raised when the step wraps past the end of the DATA_W range.
    always_comb begin
        if (dec) begin
            result = operand - DATA_W'(1);
            flag   = (operand == '0);
        end else begin
            result = operand + DATA_W'(1);
            flag   = (operand == '1);
        end
    end

endmodule

// File: rtl/reg_file_bank.sv
// Parametrised register bank with pair addressing and multi-cycle pair increment/decrement.
// Optional macro ZERO_REG_EN hardwires register 0 to zero.
module reg_file_bank
    import reg_file_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int DATA_W   = 8,
    parameter int IDX_W    = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [IDX_W-1:0]    cmd_dst,
    input  logic [IDX_W-1:0]    cmd_src,
    input  logic [DATA_W-1:0]   data_in,
    output logic [DATA_W-1:0]   data_out,
    output logic                data_out_valid,
    output logic [2*DATA_W-1:0] addr_out,
    output logic                addr_out_valid,
    output logic                busy
);

    localparam int PAIR_W = pair_idx_w(NUM_REGS);

    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    state_t              state_r, next_state_s;
    logic [PAIR_W-1:0]   carry_pair_r;
    logic                carry_dec_r;
    logic [DATA_W-1:0]   data_out_r;
    logic                data_out_valid_r;
    logic [2*DATA_W-1:0] addr_out_r;
    logic                addr_out_valid_r;

    logic                accept_s, pair_ok_s, is_step_op_s;
    logic [IDX_W-1:0]    even_idx_s, odd_idx_s, carry_even_s;
    logic [DATA_W-1:0]   step_in_s, step_out_s;
    logic                step_dec_s, step_flag_s;
    logic                wr_en_s;
    logic [IDX_W-1:0]    wr_idx_s;
    logic [DATA_W-1:0]   wr_data_s;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return 32'(idx) < NUM_REGS;
    endfunction

    function automatic logic writable(input logic [IDX_W-1:0] idx);
`ifdef ZERO_REG_EN
        return in_range(idx) && (idx != '0);
`else
        return in_range(idx);
`endif
    endfunction

    // Register 0 is never written when hardwired, so its storage stays at reset zero.
    function automatic logic [DATA_W-1:0] reg_at(input logic [IDX_W-1:0] idx);
        if (in_range(idx)) begin
            return regs_r[idx];
        end else begin
            return '0;
        end
    endfunction

    assign accept_s     = cmd_valid && (state_r == ST_IDLE);
    assign is_step_op_s = (cmd_op == OP_PAIR_INC) || (cmd_op == OP_PAIR_DEC);
    assign even_idx_s   = cmd_dst & ~IDX_W'(1);
    assign odd_idx_s    = even_idx_s | IDX_W'(1);
    assign pair_ok_s    = in_range(even_idx_s);
    assign carry_even_s = IDX_W'(carry_pair_r) << 1;

    pair_step_unit #(.DATA_W(DATA_W)) u_step (
        .operand (step_in_s),
        .dec     (step_dec_s),
        .result  (step_out_s),
        .flag    (step_flag_s)
    );

    // Next-state and single write-port selection; CARRY reuses the step unit on the high half.
    always_comb begin
        next_state_s = state_r;
        step_in_s    = '0;
        step_dec_s   = 1'b0;
        wr_en_s      = 1'b0;
        wr_idx_s     = '0;
        wr_data_s    = '0;
        case (state_r)
            ST_IDLE: begin
                step_in_s  = reg_at(odd_idx_s);
                step_dec_s = (cmd_op == OP_PAIR_DEC);
                if (accept_s) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            wr_en_s   = 1'b1;
                            wr_idx_s  = cmd_dst;
                            wr_data_s = data_in;
                        end
                        OP_MOVE: begin
                            wr_en_s   = (cmd_dst != cmd_src);
                            wr_idx_s  = cmd_dst;
                            wr_data_s = reg_at(cmd_src);
                        end
                        OP_PAIR_INC, OP_PAIR_DEC: begin
                            if (pair_ok_s) begin
                                wr_en_s   = 1'b1;
                                wr_idx_s  = odd_idx_s;
                                wr_data_s = step_out_s;
                                next_state_s = step_flag_s ? ST_CARRY : ST_IDLE;
                            end else begin
                                next_state_s = ST_IDLE;
                            end
                        end
                        default: begin
                            wr_en_s = 1'b0;
                        end
                    endcase
                end else begin
                    wr_en_s = 1'b0;
                end
            end
            ST_CARRY: begin
                step_in_s    = reg_at(carry_even_s);
                step_dec_s   = carry_dec_r;
                wr_en_s      = 1'b1;
                wr_idx_s     = carry_even_s;
                wr_data_s    = step_out_s;
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Register storage; async reset also clears a pair left half-updated by an aborted carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= '0;
            end
        end else if (wr_en_s && writable(wr_idx_s)) begin
            regs_r[wr_idx_s] <= wr_data_s;
        end
    end

    // FSM state, carry context and registered read/address outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r          <= ST_IDLE;
            carry_pair_r     <= '0;
            carry_dec_r      <= 1'b0;
            data_out_r       <= '0;
            data_out_valid_r <= 1'b0;
            addr_out_r       <= '0;
            addr_out_valid_r <= 1'b0;
        end else begin
            state_r          <= next_state_s;
            data_out_valid_r <= 1'b0;
            addr_out_valid_r <= 1'b0;
            if (accept_s && (cmd_op == OP_READ)) begin
                data_out_r       <= reg_at(cmd_src);
                data_out_valid_r <= 1'b1;
            end
            if (accept_s && (cmd_op == OP_PAIR_ADDR) && pair_ok_s) begin
                addr_out_r       <= {reg_at(even_idx_s), reg_at(odd_idx_s)};
                addr_out_valid_r <= 1'b1;
            end
            if (accept_s && is_step_op_s) begin
                carry_pair_r <= PAIR_W'(cmd_dst >> 1);
                carry_dec_r  <= (cmd_op == OP_PAIR_DEC);
            end
        end
    end

    assign cmd_ready      = (state_r == ST_IDLE);
    assign busy           = (state_r == ST_CARRY);
    assign data_out       = data_out_r;
    assign data_out_valid = data_out_valid_r;
    assign addr_out       = addr_out_r;
    assign addr_out_valid = addr_out_valid_r;

endmodule

// File: tb/tb_reg_file_bank.sv
// Self-checking bench for reg_file_bank: directed steps plus random commands checked
// against an array-based model of the eight registers (honours ZERO_REG_EN).
module tb_reg_file_bank;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [2:0]  cmd_dst;
    logic [2:0]  cmd_src;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        data_out_valid;
    logic [15:0] addr_out;
    logic        addr_out_valid;
    logic        busy;

    int total;
    int bad;

    logic [7:0]  mdl [8];
    logic [15:0] mdl_addr;
    int          exp_stall;

    reg_file_bank #(.NUM_REGS(8), .DATA_W(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_dst        (cmd_dst),
        .cmd_src        (cmd_src),
        .data_in        (data_in),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .addr_out       (addr_out),
        .addr_out_valid (addr_out_valid),
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic mwrite(input logic [2:0] idx, input logic [7:0] val);
`ifdef ZERO_REG_EN
        if (idx != 3'd0) mdl[idx] = val;
`else
        mdl[idx] = val;
`endif
    endtask

    task automatic mclear();
        for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
        mdl_addr  = 16'h0000;
        exp_stall = 0;
    endtask

    // Presents a command from a negedge, holds it until accepted; returns at the negedge after acceptance.
    task automatic do_cmd(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                          input logic [7:0] din, output int stalls);
        bit acc;
        stalls    = 0;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src   = src;
        data_in   = din;
        for (int k = 0; k < 8 && !acc; k++) begin
            acc = cmd_ready;
            @(negedge clk);
            if (!acc) stalls++;
        end
        cmd_valid = 1'b0;
        check("accept_timeout", 32'(acc), 32'd1);
    endtask

    task automatic run(input logic [2:0] op, input logic [2:0] dst, input logic [2:0] src,
                       input logic [7:0] din);
        int          stalls;
        logic [2:0]  e;
        logic [2:0]  o;
        logic [15:0] pv;
        logic        exp_busy;
        logic [7:0]  rd;
        e        = dst & 3'b110;
        o        = e | 3'b001;
        pv       = {mdl[e], mdl[o]};
        exp_busy = (op == 3'd5 && mdl[o] == 8'hFF) || (op == 3'd6 && mdl[o] == 8'h00);
        rd       = mdl[src];
        do_cmd(op, dst, src, din, stalls);
        check("stall_cycles", 32'(stalls), 32'(exp_stall));
        case (op)
            3'd1: mwrite(dst, din);
            3'd3: mwrite(dst, mdl[src]);
            3'd4: mdl_addr = pv;
            3'd5: begin pv = pv + 16'd1; mwrite(o, pv[7:0]); mwrite(e, pv[15:8]); end
            3'd6: begin pv = pv - 16'd1; mwrite(o, pv[7:0]); mwrite(e, pv[15:8]); end
            default: ;
        endcase
        check("data_out_valid", 32'(data_out_valid), 32'(op == 3'd2));
        if (op == 3'd2) check("data_out", 32'(data_out), 32'(rd));
        check("addr_out_valid", 32'(addr_out_valid), 32'(op == 3'd4));
        check("addr_out", 32'(addr_out), 32'(mdl_addr));
        check("busy", 32'(busy), 32'(exp_busy));
        check("cmd_ready", 32'(cmd_ready), 32'(!exp_busy));
        exp_stall = exp_busy ? 1 : 0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_dst   = 3'd0;
        cmd_src   = 3'd0;
        data_in   = 8'h00;
        mclear();
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_addr_out", 32'(addr_out), 32'd0);
        check("rst_valids", 32'({data_out_valid, addr_out_valid}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Every register reads zero with a one-cycle valid pulse.
        for (int i = 0; i < 8; i++) begin
            run(3'd2, 3'd0, 3'(i), 8'h00);
            check("read_zero", 32'(data_out), 32'd0);
            @(negedge clk);
            check("read_pulse_width", 32'(data_out_valid), 32'd0);
        end

        // Pair address from r2/r3.
        run(3'd1, 3'd2, 3'd0, 8'h12);
        run(3'd1, 3'd3, 3'd0, 8'h34);
        run(3'd4, 3'd2, 3'd0, 8'h00);
        check("pair_addr_1234", 32'(addr_out), 32'h1234);
        @(negedge clk);
        check("addr_pulse_width", 32'(addr_out_valid), 32'd0);
        check("addr_hold", 32'(addr_out), 32'h1234);

        // Increment with carry into the high half.
        run(3'd1, 3'd4, 3'd0, 8'h00);
        run(3'd1, 3'd5, 3'd0, 8'hFF);
        run(3'd5, 3'd4, 3'd0, 8'h00);
        run(3'd2, 3'd0, 3'd4, 8'h00);
        check("inc_carry_high", 32'(data_out), 32'h01);
        run(3'd2, 3'd0, 3'd5, 8'h00);
        check("inc_carry_low", 32'(data_out), 32'h00);

        // Full wrap in both directions.
        run(3'd1, 3'd6, 3'd0, 8'h00);
        run(3'd1, 3'd7, 3'd0, 8'h00);
        run(3'd6, 3'd7, 3'd0, 8'h00);
        run(3'd4, 3'd6, 3'd0, 8'h00);
        check("dec_wrap_ffff", 32'(addr_out), 32'hFFFF);
        run(3'd5, 3'd6, 3'd0, 8'h00);
        run(3'd4, 3'd6, 3'd0, 8'h00);
        check("inc_wrap_0000", 32'(addr_out), 32'h0000);

        // Register 0 behaviour depends on the build.
        run(3'd1, 3'd0, 3'd0, 8'hAA);
        run(3'd2, 3'd0, 3'd0, 8'h00);
`ifdef ZERO_REG_EN
        check("zero_reg_read", 32'(data_out), 32'h00);
`else
        check("zero_reg_read", 32'(data_out), 32'hAA);
`endif

        // Random traffic against the model.
        for (int n = 0; n < 400; n++) begin
            run(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                8'($urandom_range(0, 255)));
        end
        for (int i = 0; i < 8; i++) begin
            run(3'd2, 3'd0, 3'(i), 8'h00);
        end

        // Reset asserted in the middle of a carry cycle.
        run(3'd1, 3'd4, 3'd0, 8'h3C);
        run(3'd1, 3'd5, 3'd0, 8'hFF);
        run(3'd5, 3'd5, 3'd0, 8'h00);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(cmd_ready), 32'd1);
        check("abort_addr", 32'(addr_out), 32'd0);
        mclear();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run(3'd2, 3'd0, 3'(i), 8'h00);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
